// File: rtl/irig_frame_sequencer.sv
// IRIG-B frame sequencer: acquires sync on the P0->Pr double mark, tracks the
// 100-position frame, checks marker placement and publishes BCD time fields.
// Latency: outputs update on the clk edge that samples sym_valid (1 cycle).
// Backpressure: none; one symbol per cycle may arrive back-to-back.
// Ports: clk, rst_n (async active-low); sym_valid/sym_type symbol stream in;
//   locked, frame_valid, sec/min/hour/day/year (BCD), sbs, pos, sync_err,
//   err_cnt out.
// Optional feature: define IRIG_SBS_EN to capture straight binary seconds;
//   otherwise sbs is tied to zero.
module irig_frame_sequencer #(
  parameter int TIMEOUT_CYC = 1500000,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sym_valid,
  input  logic [1:0]  sym_type,
  output logic        locked,
  output logic        frame_valid,
  output logic [6:0]  sec,
  output logic [6:0]  min,
  output logic [5:0]  hour,
  output logic [9:0]  day,
  output logic [7:0]  year,
  output logic [16:0] sbs,
  output logic [6:0]  pos,
  output logic        sync_err,
  output logic [7:0]  err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {HUNT, ARM, TRACK} state_t;

  state_t        state_q, state_d;
  logic [6:0]    pos_d;
  logic [6:0]    pos_nxt;
  logic [99:0]   shadow_q;
  logic [TW-1:0] tmr_q;
  logic [3:0]    good_q, good_d, good_inc;
  logic          locked_d;
  logic          is_mark, is_bit, mark_exp, timeout;
  logic          loss, frame_done, store, publish;

  // Bit 0 and the marker slots of the shadow are never read; folding the
  // whole vector keeps the frame image intact as one object.
  logic unused_shadow;
  assign unused_shadow = ^shadow_q;

  assign is_mark  = (sym_type == 2'd2);
  assign is_bit   = ~sym_type[1];
  assign pos_nxt  = (pos == 7'd99) ? 7'd0 : pos + 7'd1;
  // Markers sit at 9,19,...,99 and at the wrap to 0 (Pr).
  assign mark_exp = (pos_nxt == 7'd0) || ((pos_nxt % 7'd10) == 7'd9);
  // A symbol arriving on the expiry cycle wins over the timeout.
  assign timeout  = !sym_valid && (tmr_q == TW'(TIMEOUT_CYC - 1)) && (state_q != HUNT);
  assign good_inc = (good_q < 4'(LOCK_FRAMES)) ? good_q + 4'd1 : good_q;

  always_comb begin
    state_d    = state_q;
    pos_d      = pos;
    loss       = 1'b0;
    frame_done = 1'b0;
    store      = 1'b0;
    case (state_q)
      HUNT: begin
        if (sym_valid && is_mark) state_d = ARM;
      end
      ARM: begin
        if (sym_valid) begin
          if (is_mark) begin
            state_d = TRACK;
            pos_d   = 7'd0;
          end else begin
            state_d = HUNT;
          end
        end else if (timeout) begin
          loss = 1'b1;
        end
      end
      TRACK: begin
        if (sym_valid) begin
          if ((sym_type == 2'd3) || (is_mark != mark_exp)) begin
            loss = 1'b1;
          end else begin
            pos_d      = pos_nxt;
            store      = is_bit;
            frame_done = is_mark && (pos_nxt == 7'd99);
          end
        end else if (timeout) begin
          loss = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
    if (loss) state_d = HUNT;

    good_d   = good_q;
    locked_d = locked;
    if (loss) begin
      good_d   = 4'd0;
      locked_d = 1'b0;
    end else if (frame_done) begin
      good_d   = good_inc;
      locked_d = locked || (good_inc == 4'(LOCK_FRAMES));
    end
    publish = frame_done && locked_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      pos         <= 7'd0;
      shadow_q    <= '0;
      tmr_q       <= '0;
      good_q      <= 4'd0;
      locked      <= 1'b0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      err_cnt     <= 8'd0;
      sec         <= '0;
      min         <= '0;
      hour        <= '0;
      day         <= '0;
      year        <= '0;
    end else begin
      state_q     <= state_d;
      pos         <= pos_d;
      good_q      <= good_d;
      locked      <= locked_d;
      frame_valid <= publish;
      sync_err    <= loss;
      if (sym_valid)
        tmr_q <= '0;
      else if (tmr_q != TW'(TIMEOUT_CYC))
        tmr_q <= tmr_q + TW'(1);
      if (store) shadow_q[pos_nxt] <= sym_type[0];
      if (loss && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      if (publish) begin
        sec  <= {shadow_q[8:6],   shadow_q[4:1]};
        min  <= {shadow_q[17:15], shadow_q[13:10]};
        hour <= {shadow_q[26:25], shadow_q[23:20]};
        day  <= {shadow_q[41:40], shadow_q[38:35], shadow_q[33:30]};
        year <= {shadow_q[58:55], shadow_q[53:50]};
      end
    end
  end

`ifdef IRIG_SBS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sbs <= '0;
    else if (publish)
      sbs <= {shadow_q[97], shadow_q[96:90], shadow_q[88:80]};
  end
`else
  assign sbs = 17'd0;
`endif

endmodule

// File: tb/tb_irig_frame_sequencer.sv
module tb_irig_frame_sequencer;

  localparam int LOCK = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sym_valid;
  logic [1:0]  sym_type;
  logic        locked, frame_valid, sync_err;
  logic [6:0]  sec, min, pos;
  logic [5:0]  hour;
  logic [9:0]  day;
  logic [7:0]  year, err_cnt;
  logic [16:0] sbs;

  always #5 clk = ~clk;

  irig_frame_sequencer #(.TIMEOUT_CYC(100), .LOCK_FRAMES(LOCK)) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_type(sym_type),
    .locked(locked), .frame_valid(frame_valid), .sec(sec), .min(min),
    .hour(hour), .day(day), .year(year), .sbs(sbs), .pos(pos),
    .sync_err(sync_err), .err_cnt(err_cnt)
  );

  typedef struct {
    bit is_frame;
    int lk, ec, s, m, h, d, y, sb;
  } ev_t;

  ev_t q[$];
  int total = 0, bad = 0;
  int good_m, err_m, p_s, p_m, p_h, p_d, p_y, p_sb;
  logic [99:0] fbits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected outcomes follow from the frame contents and the lock rules alone.
  task automatic push_err();
    good_m = 0;
    if (err_m < 255) err_m++;
    q.push_back('{0, 0, err_m, p_s, p_m, p_h, p_d, p_y, p_sb});
  endtask

  task automatic push_frame(input int h, input int m, input int s, input int d, input int y);
    if (good_m < LOCK) good_m++;
    if (good_m >= LOCK) begin
      p_s = (s / 10) * 16 + s % 10;
      p_m = (m / 10) * 16 + m % 10;
      p_h = (h / 10) * 16 + h % 10;
      p_d = (d / 100) * 256 + ((d / 10) % 10) * 16 + d % 10;
      p_y = (y / 10) * 16 + y % 10;
`ifdef IRIG_SBS_EN
      p_sb = h * 3600 + m * 60 + s;
`else
      p_sb = 0;
`endif
      q.push_back('{1, 1, err_m, p_s, p_m, p_h, p_d, p_y, p_sb});
    end
  endtask

  function automatic int rgap();
    return ($urandom_range(0, 9) < 3) ? 0 : $urandom_range(1, 3);
  endfunction

  task automatic send(input logic [1:0] t, input int gap);
    sym_valid = 1'b1;
    sym_type  = t;
    @(posedge clk); #1;
    sym_valid = 1'b0;
    sym_type  = 2'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic put(input int p, input int n, input int v);
    for (int i = 0; i < n; i++) fbits[p + i] = v[i];
  endtask

  // Sends positions 0..99; at stop_pos it either injects bad_type (expecting
  // sync loss) or, for bad_type < 0, just stops without sending.
  task automatic send_frame(input int h, input int m, input int s, input int d,
                            input int y, input int stop_pos, input int bad_type);
    int sb;
    fbits = 100'({$urandom, $urandom, $urandom, $urandom});
    sb = h * 3600 + m * 60 + s;
    put(1, 4, s % 10);  put(6, 3, s / 10);
    put(10, 4, m % 10); put(15, 3, m / 10);
    put(20, 4, h % 10); put(25, 2, h / 10);
    put(30, 4, d % 10); put(35, 4, (d / 10) % 10); put(40, 2, d / 100);
    put(50, 4, y % 10); put(55, 4, y / 10);
    put(80, 9, sb); put(90, 7, sb >> 9); put(97, 1, sb >> 16);
    for (int p = 0; p < 100; p++) begin
      bit mk;
      mk = (p == 0) || (p % 10 == 9);
      if (p == stop_pos) begin
        if (bad_type >= 0) begin
          push_err();
          send(2'(bad_type), rgap());
        end
        return;
      end
      if (p == 99) push_frame(h, m, s, d, y);
      send(mk ? 2'd2 : {1'b0, fbits[p]}, rgap());
    end
  endtask

  task automatic rand_frame(input int stop_pos, input int bad_type);
    send_frame($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59),
               $urandom_range(1, 366), $urandom_range(0, 99), stop_pos, bad_type);
  endtask

  task automatic relock();
    send(2'd2, rgap());
    rand_frame(100, 0);
    rand_frame(100, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 0);
    chk({tag, "_sec"}, 32'(sec), 0);
    chk({tag, "_min"}, 32'(min), 0);
    chk({tag, "_hour"}, 32'(hour), 0);
    chk({tag, "_day"}, 32'(day), 0);
    chk({tag, "_year"}, 32'(year), 0);
    chk({tag, "_sbs"}, 32'(sbs), 0);
    chk({tag, "_pos"}, 32'(pos), 0);
    chk({tag, "_sync_err"}, 32'(sync_err), 0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
  endtask

  task automatic model_reset();
    good_m = 0; err_m = 0;
    p_s = 0; p_m = 0; p_h = 0; p_d = 0; p_y = 0; p_sb = 0;
  endtask

  // Monitor: every frame_valid / sync_err pulse must match the next expectation.
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && (frame_valid === 1'b1 || sync_err === 1'b1)) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_event: frame_valid=%0b sync_err=%0b expected no pulse",
                   frame_valid, sync_err);
        end else begin
          e = q.pop_front();
          chk("ev_frame_valid", 32'(frame_valid), 32'(e.is_frame));
          chk("ev_sync_err", 32'(sync_err), 32'(!e.is_frame));
          chk("ev_locked", 32'(locked), e.lk);
          chk("ev_err_cnt", 32'(err_cnt), e.ec);
          chk("ev_sec", 32'(sec), e.s);
          chk("ev_min", 32'(min), e.m);
          chk("ev_hour", 32'(hour), e.h);
          chk("ev_day", 32'(day), e.d);
          chk("ev_year", 32'(year), e.y);
          chk("ev_sbs", 32'(sbs), e.sb);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; sym_valid = 1'b0; sym_type = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ARM exits without error, HUNT ignores data
    send(2'd2, 1); send(2'd0, 1);
    send(2'd2, 0); send(2'd3, 1);
    send(2'd1, 0);

    // Acquisition: P0, then two clean 12:34:56 / 123 / 24 frames
    send(2'd2, 0);
    send_frame(12, 34, 56, 123, 24, 100, 0);
    chk("locked_after_frame1", 32'(locked), 0);
    send_frame(12, 34, 56, 123, 24, 100, 0);
    chk("locked_after_frame2", 32'(locked), 1);
    chk("sec_12_34_56", 32'(sec), 32'h56);
    chk("day_123", 32'(day), 32'h123);

    repeat (4) rand_frame(100, 0);

    // Data bit where the pos 29 marker belongs
    rand_frame(29, 0);
    chk("locked_after_pos29", 32'(locked), 0);
    chk("err_cnt_after_pos29", 32'(err_cnt), 1);

    // Timeout exactly 100 idle cycles after the last symbol
    relock();
    rand_frame(50, -1);
    send(2'd0, 0);
    repeat (99) @(posedge clk);
    #1;
    chk("no_timeout_at_99", 32'(sync_err), 0);
    push_err();
    @(posedge clk); #1;
    chk("timeout_at_100", 32'(sync_err), 1);
    chk("locked_after_timeout", 32'(locked), 0);
    repeat (150) @(posedge clk);
    #1;

    // Invalid symbol at pos 45
    relock();
    rand_frame(45, 3);

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      send(2'd2, rgap());
      send(2'd2, rgap());
      push_err();
      send(2'd3, rgap());
    end
    chk("err_cnt_saturated", 32'(err_cnt), 255);

    // Random misplaced symbols at random positions
    for (int i = 0; i < 6; i++) begin
      int p;
      int bt;
      relock();
      p  = $urandom_range(1, 99);
      bt = (p % 10 == 9) ? int'($urandom_range(0, 1)) : ($urandom_range(0, 1) ? 2 : 3);
      rand_frame(p, bt);
    end

    // Reset mid-frame at pos 60 of a locked frame
    relock();
    rand_frame(60, -1);
    chk("queue_empty_before_reset", q.size(), 0);
    rst_n = 1'b0;
    #2;
    check_all_zero("midframe_reset");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(2'd2, 0);
    send_frame(12, 34, 56, 123, 24, 100, 0);
    send_frame(12, 34, 56, 123, 24, 100, 0);
    chk("relocked_after_reset", 32'(locked), 1);
`ifdef IRIG_SBS_EN
    chk("sbs_45296", 32'(sbs), 45296);
`else
    chk("sbs_tied_zero", 32'(sbs), 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty_at_end", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
